// File: rtl/uart_reg_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_reg_frame_rx
//  Purpose  : Parses checksummed write frames (HEADER, ADDR, LEN, payload,
//             CHK) from a UART byte stream and atomically commits the
//             payload into a NUM_REGS x REG_W register bank.
//  Revision : 1.0  initial release
// ============================================================================
module uart_reg_frame_rx #(
  parameter int          NUM_REGS    = 8,
  parameter int          REG_W       = 16,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic [NUM_REGS*REG_W-1:0] reg_flat,
  output logic                      frame_ok,
  output logic                      frame_err,
  output logic [1:0]                err_code,
  output logic                      busy
);

  // Bytes per register minus one; REG_W is 8..32 so this fits in 2 bits.
  localparam logic [1:0]  c_bpr_last = 2'(REG_W/8 - 1);
  localparam logic [31:0] c_tmo_last = 32'(TIMEOUT_CYC - 1);
  localparam logic [8:0]  c_num_regs = 9'(NUM_REGS);

  localparam logic [1:0]  c_err_range = 2'd1;
  localparam logic [1:0]  c_err_chk   = 2'd2;
  localparam logic [1:0]  c_err_tmo   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]                r_addr;     // first register of the frame
  logic [7:0]                r_last;     // last register of the frame
  logic [7:0]                r_widx;     // shadow register being filled
  logic [1:0]                r_bidx;     // byte position within that register
  logic [7:0]                r_xor;      // running checksum
  logic [31:0]               r_tmo;      // idle cycles since last byte
  logic [REG_W-1:0]          r_shadow [NUM_REGS];
  logic [NUM_REGS*REG_W-1:0] r_flat;
  logic                      r_ok;
  logic                      r_err;
  logic [1:0]                r_code;

  logic       w_ok;
  logic       w_err;
  logic [1:0] w_code;
  logic [8:0] w_sum;
  logic       w_last_byte;

  // End address computed at 9 bits so addr+len can never wrap.
  assign w_sum       = {1'b0, r_addr} + {1'b0, rx_data};
  assign w_last_byte = (r_widx == r_last) && (r_bidx == c_bpr_last);

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and frame decision; a byte always beats a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_code      = 2'd0;
    if (r_state != S_IDLE && !rx_valid && r_tmo == c_tmo_last) begin
      w_err       = 1'b1;
      w_code      = c_err_tmo;
      w_state_nxt = S_IDLE;
    end else if (rx_valid) begin
      case (r_state)
        S_IDLE: if (rx_data == HEADER) w_state_nxt = S_ADDR;
        S_ADDR: w_state_nxt = S_LEN;
        S_LEN: begin
          if (rx_data == 8'd0 || w_sum > c_num_regs) begin
            w_err       = 1'b1;
            w_code      = c_err_range;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: if (w_last_byte) w_state_nxt = S_CHK;
        S_CHK: begin
          if (rx_data == r_xor) begin
            w_ok = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_code = c_err_chk;
          end
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame bookkeeping: address window, byte position, checksum, timeout.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_addr <= 8'd0;
      r_last <= 8'd0;
      r_widx <= 8'd0;
      r_bidx <= 2'd0;
      r_xor  <= 8'd0;
      r_tmo  <= 32'd0;
    end else begin
      if (r_state == S_IDLE || rx_valid || w_err) r_tmo <= 32'd0;
      else                                         r_tmo <= r_tmo + 32'd1;
      if (rx_valid) begin
        case (r_state)
          S_ADDR: begin
            r_addr <= rx_data;
            r_xor  <= rx_data;
          end
          S_LEN: begin
            r_last <= 8'(w_sum - 9'd1);
            r_widx <= r_addr;
            r_bidx <= 2'd0;
            r_xor  <= r_xor ^ rx_data;
          end
          S_DATA: begin
            r_xor <= r_xor ^ rx_data;
            if (r_bidx == c_bpr_last) begin
              r_bidx <= 2'd0;
              r_widx <= r_widx + 8'd1;
            end else begin
              r_bidx <= r_bidx + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Shadow bank: payload bytes shift in MSB-first until the frame is accepted.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
    end else if (rx_valid && r_state == S_DATA) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_widx == 8'(i)) r_shadow[i] <= REG_W'({r_shadow[i], rx_data});
      end
    end
  end

  // Visible bank: every register of the frame updates on the same edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_flat <= '0;
    end else if (w_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (9'(i) >= {1'b0, r_addr} && 9'(i) <= {1'b0, r_last})
          r_flat[i*REG_W +: REG_W] <= r_shadow[i];
      end
    end
  end

  // Status pulses; the error cause holds until the next frame outcome.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ok   <= 1'b0;
      r_err  <= 1'b0;
      r_code <= 2'd0;
    end else begin
      r_ok  <= w_ok;
      r_err <= w_err;
      if (w_err)     r_code <= w_code;
      else if (w_ok) r_code <= 2'd0;
    end
  end

  assign reg_flat  = r_flat;
  assign frame_ok  = r_ok;
  assign frame_err = r_err;
  assign err_code  = r_code;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_reg_frame_rx
//  Purpose  : Directed self-checking bench for uart_reg_frame_rx.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_reg_frame_rx;

  localparam int NUM_REGS = 8;
  localparam int REG_W    = 16;
  localparam int TMO      = 40;

  logic                      clk;
  logic                      rst;
  logic                      rx_valid;
  logic [7:0]                rx_data;
  logic [NUM_REGS*REG_W-1:0] reg_flat;
  logic                      frame_ok;
  logic                      frame_err;
  logic [1:0]                err_code;
  logic                      busy;

  int n_chk;
  int n_err;

  uart_reg_frame_rx #(
    .NUM_REGS    (NUM_REGS),
    .REG_W       (REG_W),
    .HEADER      (8'hA5),
    .TIMEOUT_CYC (TMO)
  ) u_dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .reg_flat  (reg_flat),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One byte strobe; returns #1 after the edge that consumed it.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    chk("rst_flat", reg_flat, 128'h0);
    chk("rst_ok",   frame_ok, 1'b0);
    chk("rst_err",  frame_err, 1'b0);
    chk("rst_code", err_code, 2'd0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle(2);

    // Single register write to reg2.
    send(8'hA5); send(8'h02); send(8'h01); send(8'h12); send(8'h34);
    chk("t1_busy_mid", busy, 1'b1);
    chk("t1_flat_pre", reg_flat, 128'h0);
    send(8'h25);
    chk("t1_ok",   frame_ok, 1'b1);
    chk("t1_err",  frame_err, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_flat", reg_flat, 128'h0000_0000_0000_0000_0000_1234_0000_0000);
    idle(1);
    chk("t1_pulse", frame_ok, 1'b0);

    // Two registers at reg0/reg1, committed together.
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("t2_atomic", reg_flat[31:0], 32'h0);
    send(8'h02);
    chk("t2_ok",   frame_ok, 1'b1);
    chk("t2_flat", reg_flat, 128'h0000_0000_0000_0000_0000_1234_CCDD_AABB);

    // Bad checksum leaves reg2 alone; code sticks until the next outcome.
    send(8'hA5); send(8'h02); send(8'h01); send(8'h56); send(8'h78); send(8'h26);
    chk("t3_err",   frame_err, 1'b1);
    chk("t3_ok",    frame_ok, 1'b0);
    chk("t3_code",  err_code, 2'd2);
    chk("t3_reg2",  reg_flat[47:32], 16'h1234);
    idle(3);
    chk("t3_pulse", frame_err, 1'b0);
    send(8'hA5); send(8'h02); send(8'h01); send(8'h56); send(8'h78);
    chk("t3_code_hold", err_code, 2'd2);
    send(8'h2D);
    chk("t3_ok2",   frame_ok, 1'b1);
    chk("t3_code0", err_code, 2'd0);
    chk("t3_reg2b", reg_flat[47:32], 16'h5678);

    // Range errors, plus the highest legal window (reg7, len 1).
    send(8'hA5); send(8'h07); send(8'h02);
    chk("t4a_err",  frame_err, 1'b1);
    chk("t4a_code", err_code, 2'd1);
    chk("t4a_busy", busy, 1'b0);
    send(8'hA5); send(8'h03); send(8'h00);
    chk("t4b_err",  frame_err, 1'b1);
    chk("t4b_code", err_code, 2'd1);
    send(8'hA5); send(8'h07); send(8'h01);
    chk("t4c_noerr", frame_err, 1'b0);
    send(8'hAB); send(8'hCD); send(8'h60);
    chk("t4c_ok",   frame_ok, 1'b1);
    chk("t4c_reg7", reg_flat[127:112], 16'hABCD);

    // Timeout after TMO idle cycles inside a frame.
    send(8'hA5); send(8'h02);
    idle(TMO - 1);
    chk("t5_before", frame_err, 1'b0);
    chk("t5_busy",   busy, 1'b1);
    idle(1);
    chk("t5_err",  frame_err, 1'b0 | 1'b1);
    chk("t5_code", err_code, 2'd3);
    chk("t5_idle", busy, 1'b0);

    // A byte landing on the expiry cycle keeps the frame alive.
    send(8'hA5); send(8'h03);
    idle(TMO - 1);
    send(8'h01);
    chk("t5b_noerr", frame_err, 1'b0);
    chk("t5b_busy",  busy, 1'b1);
    send(8'h11); send(8'h22); send(8'h31);
    chk("t5b_ok",   frame_ok, 1'b1);
    chk("t5b_reg3", reg_flat[63:48], 16'h1122);

    // Asynchronous reset mid-payload.
    send(8'hA5); send(8'h00); send(8'h01); send(8'h55);
    rst = 1'b1;
    #1;
    chk("t6_rst_flat", reg_flat, 128'h0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_code", err_code, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    send(8'h66);
    chk("t6_ignored", busy, 1'b0);
    send(8'hA5); send(8'h04); send(8'h01); send(8'h00); send(8'h07); send(8'h02);
    chk("t6_ok",   frame_ok, 1'b1);
    chk("t6_flat", reg_flat, 128'h0000_0000_0000_0007_0000_0000_0000_0000);

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
